// File: rtl/uart_slave.sv
// Memory-mapped 8N1 UART: CTRL/STATUS/BAUD/TXDATA/RXDATA registers, a small TX FIFO,
// a single-entry RX holding buffer and a registered level interrupt for received data.
module uart_slave #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned BAUD_RST = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        we_i,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(TX_DEPTH);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_BAUD   = 8'h08;
  localparam logic [7:0] ADDR_TXDATA = 8'h0C;
  localparam logic [7:0] ADDR_RXDATA = 8'h10;

  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FIFO_FULL  = (AW + 1)'(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Register file
  logic [2:0]  ctrl_q;
  logic [15:0] baud_q;
  logic        rx_valid_q;
  logic [7:0]  rx_byte_q;
  logic        overrun_q;
  logic        frame_err_q;
  logic        irq_q;

  logic tx_en, rx_en, rx_irq_en;
  assign tx_en     = ctrl_q[0];
  assign rx_en     = ctrl_q[1];
  assign rx_irq_en = ctrl_q[2];

  logic [15:0] baud_eff, baud_reload, baud_half;
  assign baud_eff    = (baud_q < 16'd4) ? 16'd4 : baud_q;
  assign baud_reload = baud_eff - 16'd1;
  assign baud_half   = {1'b0, baud_eff[15:1]} - 16'd1;

  logic wr_ctrl, wr_status, wr_baud, wr_txdata, wr_rxdata;
  assign wr_ctrl   = we_i && (addr_i[7:0] == ADDR_CTRL);
  assign wr_status = we_i && (addr_i[7:0] == ADDR_STATUS);
  assign wr_baud   = we_i && (addr_i[7:0] == ADDR_BAUD);
  assign wr_txdata = we_i && (addr_i[7:0] == ADDR_TXDATA);
  assign wr_rxdata = we_i && (addr_i[7:0] == ADDR_RXDATA);

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], data_i[31:16]};

  // TX FIFO: pointers carry one extra wrap bit so full and empty are distinct.
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] fifo_count;
  logic        tx_full, tx_empty;
  logic        fifo_push, fifo_pop;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign tx_full    = (fifo_count == FIFO_FULL);
  assign tx_empty   = (wr_ptr_q == rd_ptr_q);
  // The drop decision looks at the count before any same-cycle pop.
  assign fifo_push  = wr_txdata && !tx_full;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop sees pre-edge values, independent of block order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q[AW-1:0]] <= data_i[7:0];
  end

  // TX state machine
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_line_q, tx_line_d;
  logic        tx_busy;

  assign tx_busy = (tx_state_q != TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_line_d  = tx_line_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (tx_en && !tx_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
          tx_cnt_d   = baud_reload;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = baud_reload;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = baud_reload;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        tx_line_d = 1'b1;
        if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
        else                tx_cnt_d   = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX path: two-flop synchronizer plus a delayed copy for falling-edge detection.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_load, rx_overrun_set, rx_frame_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_bit_d       = rx_bit_q;
    rx_load        = 1'b0;
    rx_overrun_set = 1'b0;
    rx_frame_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_en && rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = baud_half;
        end
      end
      RX_START: begin
        // Mid-start resample: a line already back high was only a glitch.
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = baud_reload;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = baud_reload;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (!rx_sync_q)      rx_frame_set   = 1'b1;
          else if (rx_valid_q) rx_overrun_set = 1'b1;
          else                 rx_load        = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Control/status registers; a new byte load beats a same-cycle CPU pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      baud_q      <= 16'(BAUD_RST);
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= data_i[2:0];
      if (wr_baud) baud_q <= data_i[15:0];

      if (rx_load) begin
        rx_byte_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (wr_rxdata) begin
        rx_valid_q <= 1'b0;
      end

      if (rx_overrun_set)              overrun_q <= 1'b1;
      else if (wr_status && data_i[3]) overrun_q <= 1'b0;

      if (rx_frame_set)                frame_err_q <= 1'b1;
      else if (wr_status && data_i[5]) frame_err_q <= 1'b0;

      irq_q <= rx_irq_en & rx_valid_q;
    end
  end

  always_comb begin
    data_o = '0;
    case (addr_i[7:0])
      ADDR_CTRL:   data_o = {29'd0, ctrl_q};
      ADDR_STATUS: data_o = {26'd0, frame_err_q, tx_busy, overrun_q, rx_valid_q, tx_empty, tx_full};
      ADDR_BAUD:   data_o = {16'd0, baud_q};
      ADDR_RXDATA: data_o = {23'd0, rx_valid_q, rx_byte_q};
      default:     data_o = '0;
    endcase
  end

  assign uart_tx_o = tx_line_q;
  assign irq_o     = irq_q;

endmodule
